// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor computing a - b - bin over WIDTH cycles

// One-bit full subtractor cell: difference and borrow-out from minuend, subtrahend and borrow-in.
module sub_cell (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic d,
    output logic br_out
);

    // Difference bit and borrow generate/propagate.
    always_comb begin
        d      = ai ^ bi ^ br;
        br_out = (~ai & bi) | (~(ai ^ bi) & br);
    end

endmodule

// Sequential subtractor: one sub_cell reused per cycle, LSB first, with a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Operands shift right so the bit being processed is always at index 0.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 difference bits produced so far; the final bit joins at completion.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_nxt;
    logic             accept;
    logic             last;
    logic             finish;

    sub_cell u_cell (
        .ai     (a_sh[0]),
        .bi     (b_sh[0]),
        .br     (br),
        .d      (d_bit),
        .br_out (br_nxt)
    );

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept  = (state == IDLE) && start;
        last    = (cnt == LAST_BIT);
        finish  = (state == RUN) && last;
        res_nxt = {d_bit, res_sh};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE waits for start, RUN lasts exactly WIDTH cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy is simply the RUN state.
    always_comb begin
        busy = (state == RUN);
    end

    // Operand, borrow and bit-counter datapath; loads on accept, shifts one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt[WIDTH-1:1];
            br     <= br_nxt;
            cnt    <= last ? '0 : cnt + 1'b1;
        end
    end

    // Result registers load together on the final bit so partial results are never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                diff     <= res_nxt;
                borrow   <= br_nxt;
                // br here is the borrow into the MSB; differing from the MSB borrow-out means signed overflow.
                overflow <= br ^ br_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH 8 and 16
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        bin8, bin16;
    logic        busy8, busy16;
    logic        done8, done16;
    logic [7:0]  diff8;
    logic [15:0] diff16;
    logic        borrow8, borrow16;
    logic        overflow8, overflow16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bl8 = 0;
    int bl16 = 0;

    typedef struct {
        logic [15:0] d;
        logic        br;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(overflow8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .overflow(overflow16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic bi, input int done_cyc);
        exp_t   e;
        longint m   = longint'(1) << w;
        longint ua  = longint'(av);
        longint ub  = longint'(bv);
        longint ub2 = longint'(bi);
        longint sa  = (ua >= m / 2) ? ua - m : ua;
        longint sb  = (ub >= m / 2) ? ub - m : ub;
        longint r   = sa - sb - ub2;
        e.d   = 16'((ua - ub - ub2) & (m - 1));
        e.br  = (ua < ub + ub2);
        e.ov  = (r < -(m / 2)) || (r >= m / 2);
        e.cyc = done_cyc;
        return e;
    endfunction

    // Scoreboard monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bl8  = 0;
            bl16 = 0;
        end else begin
            if (done8) begin
                if (q8.size() == 0) chk("done8_unexpected", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("diff8", diff8, e.d[7:0]);
                    chk("borrow8", borrow8, e.br);
                    chk("overflow8", overflow8, e.ov);
                    chk("done8_cycle", cyc, e.cyc);
                    chk("busy8_at_done", busy8, 0);
                end
            end
            if (done16) begin
                if (q16.size() == 0) chk("done16_unexpected", 1, 0);
                else begin
                    e = q16.pop_front();
                    chk("diff16", diff16, e.d);
                    chk("borrow16", borrow16, e.br);
                    chk("overflow16", overflow16, e.ov);
                    chk("done16_cycle", cyc, e.cyc);
                    chk("busy16_at_done", busy16, 0);
                end
            end
            if (busy8) bl8++;
            else if (bl8 != 0) begin
                chk("busy8_len", bl8, 8);
                bl8 = 0;
            end
            if (busy16) bl16++;
            else if (bl16 != 0) begin
                chk("busy16_len", bl16, 16);
                bl16 = 0;
            end
        end
    end

    // Drive a start for one cycle; caller ensures the DUT is idle.
    task automatic issue(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi);
        if (w == 8) begin
            start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
            q8.push_back(model(8, {8'h00, av[7:0]}, {8'h00, bv[7:0]}, bi, cyc + 1 + 8));
        end else begin
            start16 = 1'b1; a16 = av; b16 = bv; bin16 = bi;
            q16.push_back(model(16, av, bv, bi, cyc + 1 + 16));
        end
        @(posedge clk); #2;
        if (w == 8) start8 = 1'b0;
        else        start16 = 1'b0;
    endtask

    // Advance until busy drops (the done cycle), bounded.
    task automatic wait_idle(input int w);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (((w == 8) ? busy8 : busy16) && n < 100);
        if ((w == 8) ? busy8 : busy16) chk("wait_idle_timeout", 1, 0);
    endtask

    logic [7:0] dir_a [5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00};
    logic [7:0] dir_b [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00};
    logic       dir_c [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int n;
        rst = 1'b1;
        start8 = 0; start16 = 0;
        a8 = 0; b8 = 0; bin8 = 0;
        a16 = 0; b16 = 0; bin16 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", borrow8, 0);
        chk("rst_overflow", overflow8, 0);
        chk("rst_diff16", diff16, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        for (int i = 0; i < 5; i++) begin
            issue(8, {8'h00, dir_a[i]}, {8'h00, dir_b[i]}, dir_c[i]);
            wait_idle(8);
        end

        // Reset four cycles into an operation: aborts, outputs clear.
        issue(8, 16'h0055, 16'h0022, 1'b0);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        q8.delete();
        @(posedge clk); #2;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_borrow", borrow8, 0);
        chk("abort_overflow", overflow8, 0);
        rst = 1'b0;
        issue(8, 16'h0009, 16'h0004, 1'b0);
        wait_idle(8);

        // start held during busy is ignored; start in the done cycle is accepted.
        issue(8, 16'h0010, 16'h0001, 1'b0);
        @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        start8 = 1'b0;
        wait_idle(8);
        issue(8, 16'h00FF, 16'h00FF, 1'b0);
        wait_idle(8);

        issue(16, 16'h1234, 16'h1235, 1'b0);
        wait_idle(16);

        for (int i = 0; i < 40; i++) begin
            issue(8, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #2;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            wait_idle(8);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        for (int i = 0; i < 8; i++) begin
            issue(16, 16'($urandom), 16'($urandom), 1'($urandom));
            wait_idle(16);
        end

        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing `a - b - bin` over `WIDTH` cycles. It uses a single half/full-subtractor cell plus a registered borrow, with a start/done handshake. It is the sequential, width-generic successor to the combinational subtractor cells in the combinational library, and serves area-constrained datapaths that can tolerate multi-cycle latency. It reports the unsigned borrow-out and signed overflow alongside the difference.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..64.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  WIDTH  minuend; sampled with `start`.
- `b`  in  WIDTH  subtrahend; sampled with `start`.
- `bin`  in  1  borrow-in; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; results valid from this cycle onward.
- `diff`  out  WIDTH  result `(a - b - bin) mod 2^WIDTH`.
- `borrow`  out  1  final borrow-out; 1 iff `a < b + bin` (unsigned).
- `overflow`  out  1  signed (two's-complement) overflow of `a - b - bin`.

## Operation
- States: IDLE, RUN. The `done` pulse is a registered flag, not a state.
- IDLE:
  - On `start`=1, load `a`, `b` into internal shift registers and `bin` into the borrow flop.
  - Clear the bit counter and go to RUN.
  - `start`=0: stay in IDLE.
- RUN, each cycle, on the current LSBs `ai`, `bi` and borrow `br`:
  - `d = ai ^ bi ^ br`
  - `br_next = (~ai & bi) | (~(ai ^ bi) & br)`
  - Shift `d` into the MSB of the internal result register; shift the operand registers right by one.
  - Counter increments.
- Last bit (counter = WIDTH-1):
  - Borrow into the MSB is captured for overflow.
  - `overflow = borrow_into_msb ^ borrow_out`.
  - Return to IDLE.
- Completion edge:
  - `diff`, `borrow`, `overflow` output registers load together.
  - `done` is set for exactly one cycle.
- Outputs never show partial results. They hold their last completed values until the next completion or reset.
- `start` while `busy`=1 is ignored: no re-sample, no effect on the current operation.
- Input values on `a`/`b`/`bin` outside the sampling cycle have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, `overflow`=0; state IDLE; counter 0.
- `rst` has priority over `start` in the same cycle.
- Handshake sequence:
  - `start` sampled high at edge k.
  - `busy`=1 from edge k through edge k+WIDTH (exactly WIDTH cycles).
  - Bit i is processed at edge k+1+i.
  - Results and `done`=1 are registered at edge k+WIDTH; `busy` falls at the same edge.
  - Latency from start edge to done: WIDTH cycles.
- Back-to-back: `start` is accepted in the `done` cycle because `busy`=0 there. Throughput is one operation per WIDTH cycles.
- Reset mid-operation: the operation aborts with no `done` pulse. Outputs return to 0 at the next edge, and a new `start` is accepted on the cycle after reset deasserts.
- `done` never asserts without a preceding accepted `start`.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0:
  - `done` exactly 8 cycles after the start edge.
  - diff=0x02, borrow=0, overflow=0.
  - `busy` high for 8 cycles.
- WIDTH=8 signed/borrow corners:
  - 0x03-0x05 -> diff=0xFE, borrow=1, overflow=0.
  - 0x80-0x01 -> diff=0x7F, borrow=0, overflow=1.
  - 0x7F-0xFF -> diff=0x80, borrow=1, overflow=1.
- WIDTH=8, a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1, overflow=0.
- WIDTH=8 start handling:
  - Pulse `start` with a=0x10, b=0x01, then assert `start` with a=0xFF, b=0xFF during cycles 2-5 of `busy` -> first result 0x0F, borrow=0.
  - `start` asserted in the `done` cycle is accepted: second result 0x00, borrow=0, done 8 cycles later.
- WIDTH=8, assert `rst` 4 cycles into an operation:
  - No `done`; all outputs 0 the next cycle; `busy`=0.
  - A subsequent 0x09-0x04 gives 0x05.
- WIDTH=16, a=0x1234, b=0x1235, bin=0 -> diff=0xFFFF, borrow=1, overflow=0, `done` 16 cycles after start.
